// File: rtl/prog_run_ctrl_pkg.sv
// Shared types and default widths for the program load/run sequencer.
// Used by prog_run_ctrl and its cycle counter.
package run_ctrl_pkg;

  localparam int DEF_IW = 9;
  localparam int DEF_AW = 12;
  localparam int DEF_CW = 32;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HOLD,
    RUN,
    DONE,
    TOUT
  } run_state_t;

  function automatic logic state_is_busy(input run_state_t s);
    return (s == LOAD) || (s == HOLD) || (s == RUN);
  endfunction

endpackage

// File: rtl/prog_run_ctrl_cycle_counter.sv
// RUN-cycle counter with synchronous clear, count enable and a terminal-count flag
// that is high when the next increment would reach TIMEOUT.
module run_cycle_counter
  import run_ctrl_pkg::*;
#(
  parameter int          CW      = DEF_CW,
  parameter int unsigned TIMEOUT = 32'd1 << 20
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear_i,
  input  logic          enable_i,
  output logic [CW-1:0] count_o,
  output logic          at_limit_o
);

  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Clear takes priority so a restart always begins from zero.
  assign count_d = clear_i  ? '0 :
                   enable_i ? count_q + CW'(1) :
                              count_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation results.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o    = count_q;
  assign at_limit_o = (count_q == LAST);

endmodule

// File: rtl/prog_run_ctrl.sv
// Boot/run sequencer: streams a program into the instruction ROM, holds the CPU in
// reset, releases it and counts RUN cycles until done or timeout.
module prog_run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int          IW         = DEF_IW,
  parameter int          AW         = DEF_AW,
  parameter int          CW         = DEF_CW,
  parameter int          RST_CYCLES = 2,
  parameter int unsigned TIMEOUT    = 32'd1 << 20
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW:0]   prog_len,
  input  logic          load_valid,
  input  logic [IW-1:0] load_data,
  output logic          load_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [IW-1:0] imem_data,
  output logic          cpu_reset,
  input  logic          cpu_done,
  output logic          busy,
  output logic          finished,
  output logic          timed_out,
  output logic          len_err,
  output logic [CW-1:0] cycles
);

  localparam int            HW        = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_INIT = HW'(RST_CYCLES - 1);
  localparam logic [AW:0]   MAX_LEN   = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   LEN_ONE   = (AW+1)'(1);

  run_state_t    state_q;
  logic [AW-1:0] addr_q;
  logic [AW:0]   len_q;
  logic [HW-1:0] hold_q;
  logic          finished_q;
  logic          timed_out_q;
  logic          len_err_q;

  logic          len_legal;
  logic          can_start;
  logic          accept;
  logic          last_word;
  logic          run_tick;
  logic          cnt_clear;
  logic          cnt_at_limit;
  logic [CW-1:0] cnt_value;

  assign len_legal = (prog_len != '0) && (prog_len <= MAX_LEN);
  assign can_start = start && !state_is_busy(state_q);
  assign accept    = load_valid && (state_q == LOAD);
  assign last_word = ({1'b0, addr_q} == (len_q - LEN_ONE));

  // cpu_done only feeds state; it never reaches an output combinationally.
  assign run_tick  = (state_q == RUN) && !cpu_done;
  assign cnt_clear = can_start && len_legal;

  run_cycle_counter #(
    .CW      (CW),
    .TIMEOUT (TIMEOUT)
  ) u_cycle_counter (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (cnt_clear),
    .enable_i   (run_tick),
    .count_o    (cnt_value),
    .at_limit_o (cnt_at_limit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      hold_q      <= '0;
      finished_q  <= 1'b0;
      timed_out_q <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE, TOUT: begin
          if (can_start) begin
            if (len_legal) begin
              len_q       <= prog_len;
              addr_q      <= '0;
              finished_q  <= 1'b0;
              timed_out_q <= 1'b0;
              len_err_q   <= 1'b0;
              state_q     <= LOAD;
            end else begin
              len_err_q <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (accept) begin
            addr_q <= addr_q + AW'(1);
            if (last_word) begin
              hold_q  <= HOLD_INIT;
              state_q <= HOLD;
            end
          end
        end
        HOLD: begin
          if (hold_q == '0) begin
            state_q <= RUN;
          end else begin
            hold_q <= hold_q - HW'(1);
          end
        end
        RUN: begin
          // Done outranks a timeout landing on the same cycle.
          if (cpu_done) begin
            finished_q <= 1'b1;
            state_q    <= DONE;
          end else if (cnt_at_limit) begin
            timed_out_q <= 1'b1;
            state_q     <= TOUT;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign load_ready = (state_q == LOAD);
  assign imem_we    = load_valid && load_ready;
  assign imem_addr  = addr_q;
  assign imem_data  = load_ready ? load_data : '0;
  assign cpu_reset  = (state_q != RUN);
  assign busy       = state_is_busy(state_q);
  assign finished   = finished_q;
  assign timed_out  = timed_out_q;
  assign len_err    = len_err_q;
  assign cycles     = cnt_value;

endmodule
